dtree_vote_window: RTL and testbench

- Sits directly downstream of the combinational decision-tree classifier and consumes its 4-bit class output.
- Accumulates a window of consecutive per-sample predictions into per-class vote counters.
- Resolves the majority class by a sequential scan and hands the result to the readout logic through a valid/ready handshake.
- Smooths single-sample misclassifications without widening the tree itself.

---
 rtl/dtree_vote_window.sv | 193 +++++++++++++++++++
 tb/tb_dtree_vote_window.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dtree_vote_window.sv
// Majority-vote smoother for the decision-tree classifier output.
// Collects WINDOW predictions into per-class vote counters, scans the
// counters one class per cycle to find the winner, then holds the result
// behind a valid/ready handshake until the consumer takes it.
module dtree_vote_window #(
  parameter  int NUM_CLASSES = 10,
  parameter  int WINDOW      = 8,
  localparam int CW          = $clog2(WINDOW + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_class,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    out_class,
  output logic [CW-1:0] out_votes,
  output logic [CW-1:0] out_total,
  output logic          out_tie,
  output logic [CW-1:0] out_illegal
);

  // Scan index needs to reach NUM_CLASSES (up to 16) for the finalise step.
  localparam int IW = 5;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SCAN  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       sample_q, sample_d;
  logic [CW-1:0]       illegal_q, illegal_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [3:0]          best_idx_q, best_idx_d;
  logic [CW-1:0]       best_votes_q, best_votes_d;
  logic                tie_q, tie_d;
  logic [3:0]          out_class_q, out_class_d;
  logic [CW-1:0]       out_votes_q, out_votes_d;
  logic [CW-1:0]       out_total_q, out_total_d;
  logic                out_tie_q, out_tie_d;
  logic [CW-1:0]       out_illegal_q, out_illegal_d;

  logic                      accept;
  logic                      legal;
  logic                      clear_cnt;
  logic [NUM_CLASSES*CW-1:0] cnt_flat;
  logic [CW-1:0]             cur_votes;

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign accept    = (state_q == ACCUM) && in_valid;
  assign legal     = ({1'b0, in_class} < 5'(NUM_CLASSES));

  assign out_class   = out_class_q;
  assign out_votes   = out_votes_q;
  assign out_total   = out_total_q;
  assign out_tie     = out_tie_q;
  assign out_illegal = out_illegal_q;

  // One vote counter per legal class; illegal codes match no counter.
  for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_cnt
    logic [CW-1:0] cnt_q, cnt_d;

    // Count a matching accepted prediction, clear when the result is taken.
    always_comb begin
      cnt_d = cnt_q;
      if (clear_cnt) begin
        cnt_d = '0;
      end else if (accept && (in_class == 4'(gi))) begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end

    assign cnt_flat[gi*CW +: CW] = cnt_q;
  end

  // Select the counter addressed by the scan index (zero past the end).
  always_comb begin
    cur_votes = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (idx_q == IW'(i)) cur_votes = cnt_flat[i*CW +: CW];
    end
  end

  // Next-state logic: accumulate, scan for the winner, hold the result.
  always_comb begin
    state_d       = state_q;
    sample_d      = sample_q;
    illegal_d     = illegal_q;
    idx_d         = idx_q;
    best_idx_d    = best_idx_q;
    best_votes_d  = best_votes_q;
    tie_d         = tie_q;
    out_class_d   = out_class_q;
    out_votes_d   = out_votes_q;
    out_total_d   = out_total_q;
    out_tie_d     = out_tie_q;
    out_illegal_d = out_illegal_q;
    clear_cnt     = 1'b0;

    case (state_q)
      ACCUM: begin
        if (accept) begin
          sample_d = sample_q + CW'(1);
          if (!legal) illegal_d = illegal_q + CW'(1);
        end
        // The sample accepted this cycle already counts toward the flush test.
        if ((sample_d == CW'(WINDOW)) || (flush && (sample_d != '0))) begin
          state_d      = SCAN;
          idx_d        = '0;
          best_idx_d   = '0;
          best_votes_d = '0;
          tie_d        = 1'b0;
        end
      end

      SCAN: begin
        if (idx_q == IW'(NUM_CLASSES)) begin
          // All classes visited: register the result for the consumer.
          out_class_d   = best_idx_q;
          out_votes_d   = best_votes_q;
          out_total_d   = sample_q - illegal_q;
          out_tie_d     = tie_q;
          out_illegal_d = illegal_q;
          state_d       = HOLD;
        end else begin
          // Strictly-greater keeps the lowest index on ties.
          if (cur_votes > best_votes_q) begin
            best_idx_d   = idx_q[3:0];
            best_votes_d = cur_votes;
            tie_d        = 1'b0;
          end else if ((cur_votes == best_votes_q) && (best_votes_q != '0)) begin
            tie_d = 1'b1;
          end
          idx_d = idx_q + IW'(1);
        end
      end

      HOLD: begin
        if (out_ready) begin
          clear_cnt = 1'b1;
          sample_d  = '0;
          illegal_d = '0;
          state_d   = ACCUM;
        end
      end

      default: state_d = ACCUM;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ACCUM;
      sample_q      <= '0;
      illegal_q     <= '0;
      idx_q         <= '0;
      best_idx_q    <= '0;
      best_votes_q  <= '0;
      tie_q         <= 1'b0;
      out_class_q   <= '0;
      out_votes_q   <= '0;
      out_total_q   <= '0;
      out_tie_q     <= 1'b0;
      out_illegal_q <= '0;
    end else begin
      state_q       <= state_d;
      sample_q      <= sample_d;
      illegal_q     <= illegal_d;
      idx_q         <= idx_d;
      best_idx_q    <= best_idx_d;
      best_votes_q  <= best_votes_d;
      tie_q         <= tie_d;
      out_class_q   <= out_class_d;
      out_votes_q   <= out_votes_d;
      out_total_q   <= out_total_d;
      out_tie_q     <= out_tie_d;
      out_illegal_q <= out_illegal_d;
    end
  end

endmodule

// File: tb/tb_dtree_vote_window.sv
// Directed bench for dtree_vote_window (NUM_CLASSES=10, WINDOW=8).
// Expected results are queued as each window is driven and popped when the
// DUT presents out_valid.
module tb_dtree_vote_window;

  localparam int NC = 10;
  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_class;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    out_class;
  logic [CW-1:0] out_votes;
  logic [CW-1:0] out_total;
  logic          out_tie;
  logic [CW-1:0] out_illegal;

  typedef struct packed {
    logic [3:0]    cls;
    logic [CW-1:0] votes;
    logic [CW-1:0] total;
    logic          tie;
    logic [CW-1:0] ill;
  } res_t;

  res_t exp_q[$];
  int   checks_total = 0;
  int   checks_pass  = 0;

  dtree_vote_window #(.NUM_CLASSES(NC), .WINDOW(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_class   (in_class),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_class  (out_class),
    .out_votes  (out_votes),
    .out_total  (out_total),
    .out_tie    (out_tie),
    .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic send(input logic [3:0] c, input logic f);
    in_valid = 1'b1;
    in_class = c;
    flush    = f;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic send_win(input logic [3:0] s [8]);
    for (int i = 0; i < 8; i++) send(s[i], 1'b0);
  endtask

  task automatic push(input logic [3:0] c, input int v, input int t, input logic tie, input int il);
    res_t r;
    r.cls = c; r.votes = CW'(v); r.total = CW'(t); r.tie = tie; r.ill = CW'(il);
    exp_q.push_back(r);
  endtask

  // Called just after the last accept/flush edge; expects out_valid NC+1 edges later.
  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, NC + 1);
  endtask

  task automatic check_fields(input string tag, input res_t e);
    chk({tag, "_valid"},   out_valid,   1);
    chk({tag, "_inready"}, in_ready,    0);
    chk({tag, "_class"},   out_class,   e.cls);
    chk({tag, "_votes"},   out_votes,   e.votes);
    chk({tag, "_total"},   out_total,   e.total);
    chk({tag, "_tie"},     out_tie,     e.tie);
    chk({tag, "_illegal"}, out_illegal, e.ill);
    $display("txn %s: class=%0d votes=%0d total=%0d tie=%0d illegal=%0d",
             tag, out_class, out_votes, out_total, out_tie, out_illegal);
  endtask

  task automatic pop_check(input string tag);
    res_t e;
    chk({tag, "_queued"}, exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_fields(tag, e);
    end
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_drop_valid"}, out_valid, 0);
    chk({tag, "_inready_back"}, in_ready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_inready"}, in_ready,    1);
    chk({tag, "_valid"},   out_valid,   0);
    chk({tag, "_class"},   out_class,   0);
    chk({tag, "_votes"},   out_votes,   0);
    chk({tag, "_total"},   out_total,   0);
    chk({tag, "_tie"},     out_tie,     0);
    chk({tag, "_illegal"}, out_illegal, 0);
  endtask

  initial begin
    logic [3:0] s [8];
    res_t e;
    int seen;

    rst = 1'b1; in_valid = 1'b0; in_class = '0; flush = 1'b0; out_ready = 1'b0;
    #1;
    check_reset_outputs("reset_async");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_outputs("reset_release");

    // Clear majority with out_ready held high throughout.
    out_ready = 1'b1;
    s = '{4'd3, 4'd3, 4'd7, 4'd3, 4'd1, 4'd3, 4'd7, 4'd3};
    push(4'd3, 5, 8, 1'b0, 0);
    send_win(s);
    wait_valid("major");
    pop_check("major");
    release_result("major");

    // Even split: lowest index wins, tie flagged.
    s = '{4'd2, 4'd5, 4'd2, 4'd5, 4'd2, 4'd5, 4'd2, 4'd5};
    push(4'd2, 4, 8, 1'b1, 0);
    send_win(s);
    wait_valid("tie");
    pop_check("tie");
    release_result("tie");

    // Illegal codes counted separately.
    s = '{4'd12, 4'd9, 4'd9, 4'd15, 4'd9, 4'd9, 4'd9, 4'd9};
    push(4'd9, 6, 6, 1'b0, 2);
    send_win(s);
    wait_valid("illegal");
    pop_check("illegal");
    release_result("illegal");

    // All-illegal window.
    s = '{4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd10, 4'd11};
    push(4'd0, 0, 0, 1'b0, 8);
    send_win(s);
    wait_valid("allill");
    pop_check("allill");
    release_result("allill");

    // Flush on an empty window is ignored.
    flush = 1'b1;
    repeat (3) @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_empty_inready", in_ready, 1);
    chk("flush_empty_valid", out_valid, 0);

    // Partial window flushed together with its 4th sample.
    push(4'd4, 2, 4, 1'b1, 0);
    send(4'd4, 1'b0);
    send(4'd4, 1'b0);
    send(4'd6, 1'b0);
    send(4'd6, 1'b1);
    wait_valid("flush");
    pop_check("flush");
    release_result("flush");

    // Consumer stalls for 20 cycles; inputs must be ignored.
    s = '{4'd0, 4'd8, 4'd8, 4'd0, 4'd8, 4'd5, 4'd5, 4'd8};
    push(4'd8, 4, 8, 1'b0, 0);
    send_win(s);
    wait_valid("stall");
    e = exp_q.pop_front();
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_class = 4'($urandom_range(0, 15));
      flush    = 1'($urandom_range(0, 1));
      check_fields($sformatf("stall%0d", i), e);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; flush = 1'b0;
    check_fields("stall_end", e);
    release_result("stall");

    // Next window must start from zeroed counters.
    s = '{4'd6, 4'd6, 4'd6, 4'd6, 4'd6, 4'd6, 4'd6, 4'd6};
    push(4'd6, 8, 8, 1'b0, 0);
    send_win(s);
    wait_valid("clean");
    pop_check("clean");
    release_result("clean");

    // Reset in the middle of a window.
    for (int i = 0; i < 5; i++) send(4'd2, 1'b0);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk); #1 rst = 1'b0;

    // Reset during the scan: no result may appear.
    for (int i = 0; i < 8; i++) send(4'd7, 1'b0);
    chk("scan_entered_inready", in_ready, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("rst_scan");
    @(posedge clk); #1 rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    chk("rst_scan_no_result", seen, 0);

    // Full window after resets counts only fresh samples.
    s = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd1, 4'd1, 4'd1};
    push(4'd1, 5, 8, 1'b0, 0);
    send_win(s);
    wait_valid("post_rst");
    pop_check("post_rst");
    release_result("post_rst");

    chk("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end

endmodule
